// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// FSM states, Funct3 opcodes and the iteration count.
package muldiv_pkg;

  localparam int ITER = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Funct3[2] selects the divide/remainder family.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Signal bundle between the EX stage and the multiply/divide unit.
// Start is a request sampled only in IDLE (Flush wins); Busy stalls EX; Done is a one-cycle Result-valid pulse.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Funct3;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             Flush;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  modport master (
    output Start, Funct3, SrcA, SrcB, Flush,
    input  Busy, Done, Result
  );

  modport slave (
    input  Start, Funct3, SrcA, SrcB, Flush,
    output Busy, Done, Result
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, shift/subtract/restore for divide.
// acc holds {high, low}: multiply keeps the multiplier in low, divide keeps {remainder, quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opr,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, opr};
    // Trial subtract on the remainder shifted left by one; bit WIDTH flags a borrow.
    diff    = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, opr};
    acc_out = {1'b0, acc_in[2*WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) begin
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end
    end else if (acc_in[0]) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32 iterations on operand magnitudes,
// sign fix-up on the final edge, single-cycle short-circuit for divide-by-zero and overflow.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output state_t           state_dbg
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opr_q, opr_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   special_res;
  logic [2*WIDTH-1:0] step_acc;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, final_res;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_op(op_q)),
    .acc_in  (acc_q),
    .opr     (opr_q),
    .acc_out (step_acc)
  );

  // Operand decode, only meaningful in the accepting cycle.
  always_comb begin
    a_signed = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
               (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
    b_signed = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    a_neg    = a_signed && SrcA[WIDTH-1];
    b_neg    = b_signed && SrcB[WIDTH-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    div_zero = is_div_op(Funct3) && (SrcB == '0);
    div_ovf  = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
               (SrcA == MIN_NEG) && (SrcB == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = Funct3[1] ? SrcA : '1;
    end else if (div_ovf) begin
      special_res = Funct3[1] ? '0 : MIN_NEG;
    end
  end

  // Sign fix-up of the value the last iteration produces.
  always_comb begin
    prod_s = neg_q ? -step_acc : step_acc;
    quo_s  = neg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
    rem_s  = neg_rem_q ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
    case (op_q)
      F3_MUL:                          final_res = prod_s[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:    final_res = prod_s[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:                 final_res = quo_s;
      default:                         final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    opr_d     = opr_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          op_d  = Funct3;
          cnt_d = '0;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            state_d = CALC;
            if (is_div_op(Funct3)) begin
              acc_d     = {{WIDTH{1'b0}}, a_mag};
              opr_d     = b_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = a_neg;
            end else begin
              acc_d     = {{WIDTH{1'b0}}, b_mag};
              opr_d     = a_mag;
              neg_d     = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
            end
          end
        end
      end
      CALC: begin
        if (Flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d  = DONE;
            result_d = final_res;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opr_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      opr_q     <= opr_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign Busy      = (state_q == CALC);
  assign Done      = (state_q == DONE) && !Flush;
  assign Result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: driver tasks issue operations and push expected
// results; a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic   clk;
  logic   reset;
  state_t dbg;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (bus.Start),
    .Funct3    (bus.Funct3),
    .SrcA      (bus.SrcA),
    .SrcB      (bus.SrcB),
    .Flush     (bus.Flush),
    .Busy      (bus.Busy),
    .Done      (bus.Done),
    .Result    (bus.Result),
    .state_dbg (dbg)
  );

  logic [31:0] exp_q[$];
  logic [31:0] last_res;
  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && bus.Done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: Done=1 at %0t, expected no Done", $time);
      end else begin
        check("result", bus.Result, exp_q.pop_front());
      end
    end
  end

  // Issue one op (accepted at cycle 0) and watch cycles 1..done_at+3.
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int done_at,
                        input bit hold);
    int busy_n  = 0;
    int first_b = 0;
    int last_b  = 0;
    int done_n  = 0;
    int done_c  = 0;
    int both    = 0;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = f3;
    bus.SrcA   = a;
    bus.SrcB   = b;
    @(posedge clk);
    #1;
    if (!hold) bus.Start = 1'b0;
    bus.SrcA   = $urandom;
    bus.SrcB   = $urandom;
    bus.Funct3 = 3'($urandom_range(0, 7));
    for (int k = 1; k <= done_at + 3; k++) begin
      @(negedge clk);
      if (bus.Busy) begin
        busy_n++;
        if (first_b == 0) first_b = k;
        last_b = k;
      end
      if (bus.Done) begin
        done_n++;
        done_c = k;
      end
      if (bus.Busy && bus.Done) both = 1;
      if (k == done_at - 1) bus.Start = 1'b0;
    end
    check({name, "_busy_cycles"}, busy_n, done_at - 1);
    check({name, "_first_busy"}, first_b, (done_at > 1) ? 1 : 0);
    check({name, "_last_busy"}, last_b, done_at - 1);
    check({name, "_done_count"}, done_n, 1);
    check({name, "_done_cycle"}, done_c, done_at);
    check({name, "_busy_and_done"}, both, 0);
    last_res = exp;
  endtask

  initial begin
    reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Flush  = 1'b0;
    bus.Funct3 = 3'b000;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    last_res   = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_result", bus.Result, 0);
    check("rst_state", dbg, IDLE);
    reset = 1'b0;

    run_op("mul_7",         F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
    run_op("mulhu_ff",      F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
    run_op("mulh_ff",       F3_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, 0);
    run_op("mulhsu_m1x2",   F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("mulh_min",      F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
    run_op("div_m7_2",      F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 0);
    run_op("rem_m7_2",      F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 0);
    run_op("divu_100_7",    F3_DIVU,   32'd100,      32'd7,        32'd14,       33, 0);
    run_op("remu_100_7",    F3_REMU,   32'd100,      32'd7,        32'd2,        33, 0);
    run_op("div_min_1",     F3_DIV,    32'h80000000, 32'd1,        32'h80000000, 33, 0);
    run_op("divu_5_0",      F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
    run_op("rem_5_0",       F3_REM,    32'd5,        32'd0,        32'd5,        1,  0);
    run_op("rem_ovf",       F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
    run_op("div_ovf",       F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);

    // Start together with Flush in IDLE must not be accepted.
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Flush  = 1'b1;
    bus.Funct3 = F3_MUL;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd3;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", bus.Busy, 0);
    check("flush_start_state", dbg, IDLE);
    repeat (3) @(negedge clk);

    // Flush at cycle 10 of a running multiply.
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = F3_MUL;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd5;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_c10_busy", bus.Busy, 1);
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    @(negedge clk);
    check("flush_c11_state", dbg, IDLE);
    check("flush_c11_busy", bus.Busy, 0);
    check("flush_c11_done", bus.Done, 0);
    check("flush_c11_result", bus.Result, last_res);
    run_op("after_flush", F3_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);

    // Reset asserted at cycle 20 of a running multiply.
    @(negedge clk);
    bus.Start  = 1'b1;
    bus.Funct3 = F3_MUL;
    bus.SrcA   = 32'd9;
    bus.SrcB   = 32'd9;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_busy", bus.Busy, 1);
    reset = 1'b1;
    #1;
    check("mid_reset_busy", bus.Busy, 0);
    check("mid_reset_done", bus.Done, 0);
    check("mid_reset_result", bus.Result, 0);
    check("mid_reset_state", dbg, IDLE);
    last_res = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset",   F3_MUL, 32'd6, 32'd7,  32'd42, 33, 0);
    run_op("start_held",   F3_MUL, 32'd5, 32'd11, 32'd55, 33, 1);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
